// File: rtl/ay8_pkg.sv
// ay8_pkg: shared types and constants for the AY8 fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, ADDR, DATA, HOLD)
//   AY8_RESET_PC  : default program counter after reset
//   BUS_RD/BUS_WR : uniBus direction encodings for the bus_rd line
package ay8_pkg;

    localparam logic [7:0] AY8_RESET_PC = 8'h00;
    localparam logic       BUS_RD       = 1'b1;
    localparam logic       BUS_WR       = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ay8_fetch_buf.sv
// ay8_fetch_buf: one-entry prefetch register holding a fetched byte and the
// address it came from, so the bus can run ahead of the decoder by one byte.
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous reset, active-high (empties the entry)
//   load       in   capture load_data/load_pc and mark the entry valid
//   load_data  in   fetched byte
//   load_pc    in   address of the fetched byte
//   drain      in   entry consumed this cycle
//   flush      in   discard the entry (redirect); wins over load and drain
//   valid      out  entry holds a byte
//   data       out  buffered byte
//   pc         out  address of the buffered byte
module ay8_fetch_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] load_pc,
    input  logic              drain,
    input  logic              flush,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // NOTE: the payload has no reset on purpose; valid alone says whether it
    // means anything, so clearing data/pc would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
            pc   <= load_pc;
        end
    end

endmodule

// File: rtl/ay8_fetch_unit.sv
// ay8_fetch_unit: AY8 instruction fetch stage. Reads one byte per two-phase
// uniBus transaction (address phase, then data phase) and hands it to the
// decoder over a valid/ready handshake.
// Build option: define AY8_FETCH_PREFETCH_EN to add a one-entry prefetch
// buffer (ay8_fetch_buf) so the bus keeps fetching while the decoder stalls.
// Ports:
//   CLK          in   system clock, all logic on posedge
//   RST          in   synchronous reset, active-high, wins over everything
//   bus_in       in   sampled uniBus value (memory drives it in data phase)
//   bus_out      out  value driven onto uniBus while bus_oe=1 (0 otherwise)
//   bus_oe       out  fetch unit owns uniBus this cycle
//   bus_start    out  address-phase strobe, one cycle per transaction
//   bus_rd       out  read/write select, always read
//   stall        in   blocks the start of a new transaction
//   pc_load      in   redirect fetch to pc_load_val
//   pc_load_val  in   redirect target
//   instr_valid  out  instr_data/instr_pc hold a fetched byte
//   instr_ready  in   decoder accepts the byte this cycle
//   instr_data   out  fetched byte
//   instr_pc     out  address the byte was fetched from
//   pc           out  address of the next bus fetch
module ay8_fetch_unit
    import ay8_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] RESET_PC = AY8_RESET_PC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              bus_start,
    output logic              bus_rd,
    input  logic              stall,
    input  logic              pc_load,
    input  logic [DATA_W-1:0] pc_load_val,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [DATA_W-1:0] instr_pc,
    output logic [DATA_W-1:0] pc
);

    fetch_state_t state, state_nxt;
    logic         discard;     // in-flight transaction belongs to a stale pc
    logic         handshake;
    logic         byte_done;   // data phase ends with a byte worth keeping
    logic         to_instr;    // that byte goes straight to instr_*
    logic         enter_hold;  // DATA must wait in HOLD for the decoder
    logic         start_ok;    // IDLE may launch a new transaction

    assign handshake = instr_valid & instr_ready;
    assign byte_done = (state == DATA) && !discard && !pc_load;
    assign bus_rd    = BUS_RD;

`ifdef AY8_FETCH_PREFETCH_EN
    logic              buf_valid;
    logic              buf_drain;
    logic              to_buf;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] buf_pc;

    // A new byte skips the buffer whenever the output slot is free or is
    // being emptied this very cycle; the buffer is empty during DATA because
    // a transaction only starts with it empty.
    assign to_instr   = byte_done && (!instr_valid || handshake);
    assign to_buf     = byte_done && instr_valid && !instr_ready;
    assign buf_drain  = handshake && buf_valid;
    assign enter_hold = to_buf;
    assign start_ok   = !buf_valid;

    ay8_fetch_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (CLK),
        .rst       (RST),
        .load      (to_buf),
        .load_data (bus_in),
        .load_pc   (pc),
        .drain     (buf_drain),
        .flush     (pc_load),
        .valid     (buf_valid),
        .data      (buf_data),
        .pc        (buf_pc)
    );
`else
    assign to_instr   = byte_done;
    assign enter_hold = byte_done;
    assign start_ok   = !instr_valid;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the design samples the values from before the clock edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        bus_oe    = 1'b0;
        bus_start = 1'b0;
        bus_out   = '0;
        case (state)
            IDLE: begin
                if (!stall && start_ok) state_nxt = ADDR;
            end
            ADDR: begin
                bus_oe    = 1'b1;
                bus_start = 1'b1;
                bus_out   = pc;
                // Memory expects a data phase once strobed, redirect or not.
                state_nxt = DATA;
            end
            DATA: begin
                if (enter_hold) state_nxt = HOLD;
                else            state_nxt = stall ? IDLE : ADDR;
            end
            HOLD: begin
                if (handshake || pc_load) state_nxt = stall ? IDLE : ADDR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc          <= RESET_PC;
            discard     <= 1'b0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else begin
            // A discarded data phase must not advance the already-loaded pc.
            if (pc_load)                         pc <= pc_load_val;
            else if (state == DATA && !discard)  pc <= pc + DATA_W'(1);

            if (state == ADDR && pc_load) discard <= 1'b1;
            else if (state == DATA)       discard <= 1'b0;

            if (pc_load) begin
                instr_valid <= 1'b0;
            end else if (to_instr) begin
                instr_valid <= 1'b1;
                instr_data  <= bus_in;
                instr_pc    <= pc;
`ifdef AY8_FETCH_PREFETCH_EN
            end else if (buf_drain) begin
                instr_valid <= 1'b1;
                instr_data  <= buf_data;
                instr_pc    <= buf_pc;
`endif
            end else if (handshake) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ay8_fetch_unit.sv
// tb_ay8_fetch_unit: self-checking bench for ay8_fetch_unit. A memory model
// answers each transaction with mem[a] = a + 8'h10. A second instance built
// with RESET_PC=FE covers the pc wrap.
module tb_ay8_fetch_unit;

    typedef struct packed {
        logic       ready;
        logic       start;
        logic       oe;
        logic [7:0] out;
        logic       valid;
        logic [7:0] data;
        logic [7:0] ipc;
        logic [7:0] pc;
    } vec_t;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] data;
    } item_t;

`ifdef AY8_FETCH_PREFETCH_EN
    localparam int T1_EXTRA    = 2;
    localparam int T3_DATA     = 4;
    localparam int T4_ADDR     = 3;
    localparam int HOLD_STARTS = 1;
`else
    localparam int T1_EXTRA    = 5;
    localparam int T3_DATA     = 5;
    localparam int T4_ADDR     = 4;
    localparam int HOLD_STARTS = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] bus_in, bus_out, pc_load_val, instr_data, instr_pc, pc;
    logic       bus_oe, bus_start, bus_rd, stall, pc_load, instr_valid, instr_ready;

    logic       fe_rst = 1'b1;
    logic       fe_stall = 1'b0, fe_pc_load = 1'b0, fe_ready = 1'b1;
    logic [7:0] fe_pc_load_val = 8'h00;
    logic [7:0] fe_bus_in, fe_bus_out, fe_instr_data, fe_instr_pc, fe_pc;
    logic       fe_bus_oe, fe_bus_start, fe_bus_rd, fe_instr_valid;

    logic [7:0] mem_addr = 8'h00;
    logic [7:0] fe_mem_addr = 8'h00;

    int    n_tests = 0;
    int    n_fail  = 0;
    vec_t  vecs[8];
    item_t exp_q[$];
    item_t fe_q[$];

    always #5 CLK = ~CLK;

    ay8_fetch_unit dut (
        .CLK(CLK), .RST(RST), .bus_in(bus_in), .bus_out(bus_out),
        .bus_oe(bus_oe), .bus_start(bus_start), .bus_rd(bus_rd),
        .stall(stall), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .pc(pc)
    );

    ay8_fetch_unit #(.RESET_PC(8'hFE)) dut_fe (
        .CLK(CLK), .RST(fe_rst), .bus_in(fe_bus_in), .bus_out(fe_bus_out),
        .bus_oe(fe_bus_oe), .bus_start(fe_bus_start), .bus_rd(fe_bus_rd),
        .stall(fe_stall), .pc_load(fe_pc_load), .pc_load_val(fe_pc_load_val),
        .instr_valid(fe_instr_valid), .instr_ready(fe_ready),
        .instr_data(fe_instr_data), .instr_pc(fe_instr_pc), .pc(fe_pc)
    );

    // Memory: latch the address on the strobe, answer during the data phase.
    always @(posedge CLK) begin
        if (bus_oe && bus_start)       mem_addr    <= bus_out;
        if (fe_bus_oe && fe_bus_start) fe_mem_addr <= fe_bus_out;
    end
    assign bus_in    = mem_addr + 8'h10;
    assign fe_bus_in = fe_mem_addr + 8'h10;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic st, input logic oe,
                                input logic [7:0] out, input logic v, input logic [7:0] d,
                                input logic [7:0] ip, input logic [7:0] p);
        vec_t r;
        r.ready = rdy; r.start = st; r.oe = oe; r.out = out;
        r.valid = v; r.data = d; r.ipc = ip; r.pc = p;
        return r;
    endfunction

    function automatic item_t mk_item(input logic [7:0] a, input logic [7:0] d);
        item_t r;
        r.pc = a;
        r.data = d;
        return r;
    endfunction

    task automatic do_reset(input logic stall_v);
        RST = 1'b1; instr_ready = 1'b0; pc_load = 1'b0; stall = stall_v;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            @(posedge CLK); #1;
            if (exp_q.size() == 0) break;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        instr_ready = 1'b0;
    endtask

    // Scoreboard: every accepted byte must match the head of the queue.
    always @(negedge CLK) begin
        item_t it;
        if (!RST && instr_valid && instr_ready) begin
            check("sb_byte_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                check($sformatf("sb_fetch_%02h", it.pc), 64'({instr_pc, instr_data}),
                      64'({it.pc, it.data}));
            end
        end
    end

    always @(negedge CLK) begin
        item_t it;
        if (!fe_rst && fe_instr_valid && fe_q.size() != 0) begin
            it = fe_q.pop_front();
            check($sformatf("wrap_fetch_%02h", it.pc), 64'({fe_instr_pc, fe_instr_data}),
                  64'({it.pc, it.data}));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int starts;
        int stable;
        logic got_start;

`ifdef AY8_FETCH_PREFETCH_EN
        vecs[0] = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        vecs[1] = mk(1, 1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        vecs[2] = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        vecs[3] = mk(1, 1, 1, 8'h01, 1, 8'h10, 8'h00, 8'h01);
        vecs[4] = mk(1, 0, 0, 8'h00, 0, 8'h10, 8'h00, 8'h01);
        vecs[5] = mk(1, 1, 1, 8'h02, 1, 8'h11, 8'h01, 8'h02);
        vecs[6] = mk(1, 0, 0, 8'h00, 0, 8'h11, 8'h01, 8'h02);
        vecs[7] = mk(1, 1, 1, 8'h03, 1, 8'h12, 8'h02, 8'h03);
`else
        vecs[0] = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        vecs[1] = mk(1, 1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        vecs[2] = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        vecs[3] = mk(1, 0, 0, 8'h00, 1, 8'h10, 8'h00, 8'h01);
        vecs[4] = mk(1, 1, 1, 8'h01, 0, 8'h10, 8'h00, 8'h01);
        vecs[5] = mk(1, 0, 0, 8'h00, 0, 8'h10, 8'h00, 8'h01);
        vecs[6] = mk(1, 0, 0, 8'h00, 1, 8'h11, 8'h01, 8'h02);
        vecs[7] = mk(1, 1, 1, 8'h02, 0, 8'h11, 8'h01, 8'h02);
`endif

        stall = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00; instr_ready = 1'b0;

        // Reset values while RST is held.
        @(posedge CLK); @(negedge CLK);
        check("reset_state",
              64'({bus_oe, bus_start, bus_out, bus_rd, instr_valid, instr_data, instr_pc, pc}),
              64'({1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00}));
        check("wrap_reset_state", 64'({fe_pc, fe_bus_rd}), 64'({8'hFE, 1'b1}));

        // Streaming fetch from address 0 with the decoder always ready.
        do_reset(1'b0);
        for (int a = 0; a < 4; a++) exp_q.push_back(mk_item(8'(a), 8'(a + 16)));
        for (int i = 0; i < 8; i++) begin
            instr_ready = vecs[i].ready;
            @(negedge CLK);
            check($sformatf("vec%0d", i),
                  64'({bus_start, bus_oe, bus_out, instr_valid, instr_data, instr_pc, pc}),
                  64'({vecs[i].start, vecs[i].oe, vecs[i].out, vecs[i].valid,
                       vecs[i].data, vecs[i].ipc, vecs[i].pc}));
            @(posedge CLK); #1;
        end
        repeat (T1_EXTRA) begin @(posedge CLK); #1; end
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Decoder back-pressure for 5 cycles after the first byte.
        do_reset(1'b0);
        repeat (3) begin @(posedge CLK); #1; end
        starts = 0;
        stable = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            starts += int'(bus_start);
            if (instr_valid && instr_data == 8'h10 && instr_pc == 8'h00) stable++;
            @(posedge CLK); #1;
        end
        check("hold_bus_starts", 64'(starts), 64'(HOLD_STARTS));
        check("hold_output_stable", 64'(stable), 64'd5);
        exp_q.push_back(mk_item(8'h00, 8'h10));
        instr_ready = 1'b1;
        @(posedge CLK); #1;
        instr_ready = 1'b0;
        check("hold_release", 64'(exp_q.size()), 64'd0);

        // Redirect during the data phase of the fetch at 01.
        do_reset(1'b0);
        instr_ready = 1'b1;
        exp_q.push_back(mk_item(8'h00, 8'h10));
        exp_q.push_back(mk_item(8'h80, 8'h90));
        repeat (T3_DATA) begin @(posedge CLK); #1; end
        pc_load = 1'b1;
        pc_load_val = 8'h80;
        @(posedge CLK); #1;
        pc_load = 1'b0;
        @(negedge CLK);
        check("redirect_pc", 64'(pc), 64'h80);
        got_start = 1'b0;
        for (int k = 0; k < 8 && !got_start; k++) begin
            if (k != 0) @(negedge CLK);
            if (bus_start) begin
                got_start = 1'b1;
                check("redirect_bus_out", 64'(bus_out), 64'h80);
            end
        end
        check("redirect_start_seen", 64'(got_start), 64'd1);
        wait_drain("redirect_drained", 12);

        // Reset in the address phase of the second fetch.
        do_reset(1'b0);
        instr_ready = 1'b1;
`ifndef AY8_FETCH_PREFETCH_EN
        exp_q.push_back(mk_item(8'h00, 8'h10));
`endif
        repeat (T4_ADDR) begin @(posedge CLK); #1; end
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid_in_addr", 64'({bus_start, bus_out}), 64'({1'b1, 8'h01}));
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_mid_state", 64'({bus_oe, instr_valid, pc}), 64'({1'b0, 1'b0, 8'h00}));
        RST = 1'b0;
        exp_q.push_back(mk_item(8'h00, 8'h10));
        wait_drain("rst_mid_refetch", 12);

        // Stall from reset, then release.
        do_reset(1'b1);
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            starts += int'(bus_start);
            @(posedge CLK); #1;
        end
        check("stall_no_start", 64'(starts), 64'd0);
        stall = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("stall_release_start", 64'({bus_start, bus_oe, bus_out}), 64'({1'b1, 1'b1, 8'h00}));
        @(posedge CLK); #1;
        RST = 1'b1;

        // Address wrap from RESET_PC=FE.
        fe_q.push_back(mk_item(8'hFE, 8'h0E));
        fe_q.push_back(mk_item(8'hFF, 8'h0F));
        fe_q.push_back(mk_item(8'h00, 8'h10));
        fe_q.push_back(mk_item(8'h01, 8'h11));
        fe_rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge CLK); #1;
            if (fe_q.size() == 0) break;
        end
        check("wrap_drained", 64'(fe_q.size()), 64'd0);
        fe_rst = 1'b1;

        check("sb_final_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
